// File: rtl/memory_access.sv
// memory_access -- MEM stage of the 5-stage MIPS pipeline.
//
// Takes the EX/MEM register (XM_*, ALUout), runs loads/stores against an
// external word-addressed data memory using a req/ack handshake, and
// produces the MEM/WB register (MW_*). While an access is outstanding the
// upstream stages are held with `stall`. Misaligned accesses and bus
// timeouts raise sticky error flags that only `rst` clears.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   XM_MemtoReg/RegWrite/MemRead/MemWrite/branch   EX/MEM control bits
//   ALUout, XM_MD, XM_RD, XM_BT                     EX/MEM data
//   dmem_req/we/addr/wdata   request to data memory (combinational)
//   dmem_ack, dmem_rdata     response from data memory
//   stall                    hold upstream stages this cycle
//   PCSrc, BT                branch pass-through
//   MW_MemtoReg/RegWrite/ALUout/MDR/RD              MEM/WB register
//   align_err, bus_err       sticky error flags
module memory_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        XM_MemtoReg,
  input  logic        XM_RegWrite,
  input  logic        XM_MemRead,
  input  logic        XM_MemWrite,
  input  logic        XM_branch,
  input  logic [31:0] ALUout,
  input  logic [31:0] XM_MD,
  input  logic [4:0]  XM_RD,
  input  logic [31:0] XM_BT,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] BT,
  output logic        MW_MemtoReg,
  output logic        MW_RegWrite,
  output logic [31:0] MW_ALUout,
  output logic [31:0] MW_MDR,
  output logic [4:0]  MW_RD,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // Request captured when an access starts; replayed while waiting.
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic        lat_we_q, lat_we_d;
  logic        lat_ld_q, lat_ld_d;
  logic        lat_m2r_q, lat_m2r_d;
  logic        lat_rw_q, lat_rw_d;
  logic [4:0]  lat_dst_q, lat_dst_d;

  logic        mw_m2r_q, mw_m2r_d;
  logic        mw_rw_q, mw_rw_d;
  logic [31:0] mw_alu_q, mw_alu_d;
  logic [31:0] mw_mdr_q, mw_mdr_d;
  logic [4:0]  mw_rd_q, mw_rd_d;
  logic        align_q, align_d;
  logic        bus_q, bus_d;

  logic mop, misalign, start, in_wait, timeout_hit, is_load;

  assign mop         = XM_MemRead | XM_MemWrite;
  assign misalign    = mop & (ALUout[1:0] != 2'b00);
  assign start       = (state_q == S_IDLE) & mop & ~misalign;
  assign in_wait     = (state_q == S_WAIT);
  assign timeout_hit = in_wait & (cnt_q == 8'(TIMEOUT));
  // Read+write together behaves as a write, so only a pure read loads MDR.
  assign is_load     = XM_MemRead & ~XM_MemWrite;

  // Request side: never looks at dmem_rdata, and goes quiet during reset.
  assign dmem_req   = ~rst & (start | in_wait);
  assign dmem_we    = in_wait ? lat_we_q    : XM_MemWrite;
  assign dmem_addr  = in_wait ? lat_addr_q  : ALUout;
  assign dmem_wdata = in_wait ? lat_wdata_q : XM_MD;
  // On the timeout cycle stall drops so the aborted op retires.
  assign stall      = ~rst & ((start & ~dmem_ack) |
                              (in_wait & ~dmem_ack & ~timeout_hit));

  assign PCSrc = ~rst & XM_branch;
  assign BT    = XM_BT;

  assign MW_MemtoReg = mw_m2r_q;
  assign MW_RegWrite = mw_rw_q;
  assign MW_ALUout   = mw_alu_q;
  assign MW_MDR      = mw_mdr_q;
  assign MW_RD       = mw_rd_q;
  assign align_err   = align_q;
  assign bus_err     = bus_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_we_d    = lat_we_q;
    lat_ld_d    = lat_ld_q;
    lat_m2r_d   = lat_m2r_q;
    lat_rw_d    = lat_rw_q;
    lat_dst_d   = lat_dst_q;
    mw_m2r_d    = mw_m2r_q;
    mw_rw_d     = mw_rw_q;
    mw_alu_d    = mw_alu_q;
    mw_mdr_d    = mw_mdr_q;
    mw_rd_d     = mw_rd_q;
    align_d     = align_q;
    bus_d       = bus_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lat_addr_d  = ALUout;
          lat_wdata_d = XM_MD;
          lat_we_d    = XM_MemWrite;
          lat_ld_d    = is_load;
          lat_m2r_d   = XM_MemtoReg;
          lat_rw_d    = XM_RegWrite;
          lat_dst_d   = XM_RD;
          if (dmem_ack) begin
            mw_m2r_d = XM_MemtoReg;
            mw_rw_d  = XM_RegWrite;
            mw_alu_d = ALUout;
            mw_rd_d  = XM_RD;
            if (is_load) mw_mdr_d = dmem_rdata;
          end else begin
            state_d  = S_WAIT;
            cnt_d    = 8'd1;
            mw_m2r_d = 1'b0;
            mw_rw_d  = 1'b0;
          end
        end else begin
          // Plain ALU op, or a misaligned access that is dropped on the floor.
          mw_m2r_d = XM_MemtoReg;
          mw_rw_d  = XM_RegWrite & ~misalign;
          mw_alu_d = ALUout;
          mw_rd_d  = XM_RD;
          if (misalign) align_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          // Ack beats a coincident timeout.
          state_d  = S_IDLE;
          cnt_d    = 8'd0;
          mw_m2r_d = lat_m2r_q;
          mw_rw_d  = lat_rw_q;
          mw_alu_d = lat_addr_q;
          mw_rd_d  = lat_dst_q;
          if (lat_ld_q) mw_mdr_d = dmem_rdata;
        end else if (timeout_hit) begin
          state_d  = S_IDLE;
          cnt_d    = 8'd0;
          bus_d    = 1'b1;
          mw_m2r_d = lat_m2r_q;
          mw_rw_d  = 1'b0;
          mw_alu_d = lat_addr_q;
          mw_rd_d  = lat_dst_q;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          mw_m2r_d = 1'b0;
          mw_rw_d  = 1'b0;
        end
      end
    endcase
  end

  // Control state, MEM/WB register and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      mw_m2r_q <= 1'b0;
      mw_rw_q  <= 1'b0;
      mw_alu_q <= 32'd0;
      mw_mdr_q <= 32'd0;
      mw_rd_q  <= 5'd0;
      align_q  <= 1'b0;
      bus_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mw_m2r_q <= mw_m2r_d;
      mw_rw_q  <= mw_rw_d;
      mw_alu_q <= mw_alu_d;
      mw_mdr_q <= mw_mdr_d;
      mw_rd_q  <= mw_rd_d;
      align_q  <= align_d;
      bus_q    <= bus_d;
    end
  end

  // Captured request; only consumed in WAIT, which always follows a capture.
  always_ff @(posedge clk) begin
    lat_addr_q  <= lat_addr_d;
    lat_wdata_q <= lat_wdata_d;
    lat_we_q    <= lat_we_d;
    lat_ld_q    <= lat_ld_d;
    lat_m2r_q   <= lat_m2r_d;
    lat_rw_q    <= lat_rw_d;
    lat_dst_q   <= lat_dst_d;
  end

endmodule

// File: tb/tb_memory_access.sv
// Testbench for memory_access: directed cases followed by random ops, each
// op scored against a transaction-level reference model.
module tb_memory_access;

  localparam int TO    = 4;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch;
  logic [31:0] ALUout, XM_MD, XM_BT;
  logic [4:0]  XM_RD;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, PCSrc;
  logic [31:0] BT;
  logic        MW_MemtoReg, MW_RegWrite;
  logic [31:0] MW_ALUout, MW_MDR;
  logic [4:0]  MW_RD;
  logic        align_err, bus_err;

  memory_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
    .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite), .XM_branch(XM_branch),
    .ALUout(ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD), .XM_BT(XM_BT),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .PCSrc(PCSrc), .BT(BT),
    .MW_MemtoReg(MW_MemtoReg), .MW_RegWrite(MW_RegWrite),
    .MW_ALUout(MW_ALUout), .MW_MDR(MW_MDR), .MW_RD(MW_RD),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model of the MEM/WB register and error flags.
  logic        e_m2r, e_rw, e_align, e_bus;
  logic [31:0] e_alu, e_mdr;
  logic [4:0]  e_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    e_m2r = 1'b0; e_rw = 1'b0; e_alu = 32'd0; e_mdr = 32'd0; e_rd = 5'd0;
    e_align = 1'b0; e_bus = 1'b0;
  endtask

  task automatic chk_mw(input string tag);
    chk({tag, ".m2r"},   32'(MW_MemtoReg), 32'(e_m2r));
    chk({tag, ".rw"},    32'(MW_RegWrite), 32'(e_rw));
    chk({tag, ".alu"},   MW_ALUout, e_alu);
    chk({tag, ".mdr"},   MW_MDR, e_mdr);
    chk({tag, ".rd"},    32'(MW_RD), 32'(e_rd));
    chk({tag, ".align"}, 32'(align_err), 32'(e_align));
    chk({tag, ".bus"},   32'(bus_err), 32'(e_bus));
  endtask

  // One instruction through MEM. lat = cycles from request start to ack
  // (0 = same cycle, > TO = memory never answers).
  task automatic do_op(input string tag, input logic mr, input logic mw,
                       input logic m2r, input logic rw, input logic [31:0] addr,
                       input logic [31:0] md, input logic [4:0] rd,
                       input int lat, input logic [31:0] rdv);
    logic [31:0] r;
    logic mop, mis, acc, tmo;
    int   e;
    mop = mr | mw;
    mis = mop && (addr[1:0] != 2'b00);
    acc = mop && !mis;
    tmo = acc && (lat > TO);
    e   = !acc ? 0 : (lat <= TO ? lat : TO);

    XM_MemRead = mr; XM_MemWrite = mw; XM_MemtoReg = m2r; XM_RegWrite = rw;
    ALUout = addr; XM_MD = md; XM_RD = rd;
    for (int k = 0; k <= e; k++) begin
      r = $urandom;
      XM_branch = r[5];
      XM_BT     = $urandom;
      if (k > 0) begin
        // Upstream is stalled but the MEM stage must not care what it shows.
        XM_MemRead = r[0]; XM_MemWrite = r[1]; XM_MemtoReg = r[2];
        XM_RegWrite = r[3]; ALUout = $urandom; XM_MD = $urandom;
        XM_RD = 5'($urandom);
      end
      dmem_ack   = acc ? (k == lat) : r[4];
      dmem_rdata = (acc && k == lat) ? rdv : $urandom;
      #1;
      chk({tag, ".req"},   32'(dmem_req), 32'(acc));
      chk({tag, ".stall"}, 32'(stall), 32'(acc && (k < e)));
      chk({tag, ".pcsrc"}, 32'(PCSrc), 32'(XM_branch));
      chk({tag, ".bt"},    BT, XM_BT);
      if (acc) begin
        chk({tag, ".addr"},  dmem_addr, addr);
        chk({tag, ".wdata"}, dmem_wdata, md);
        chk({tag, ".we"},    32'(dmem_we), 32'(mw));
      end
      @(posedge clk); #1;
      if (k < e) begin
        chk({tag, ".bub_rw"},  32'(MW_RegWrite), 32'd0);
        chk({tag, ".bub_m2r"}, 32'(MW_MemtoReg), 32'd0);
        chk({tag, ".bub_rd"},  32'(MW_RD), 32'(e_rd));
        chk({tag, ".bub_alu"}, MW_ALUout, e_alu);
      end
    end
    dmem_ack = 1'b0;

    e_m2r = m2r;
    e_rw  = rw && !mis && !tmo;
    e_alu = addr;
    e_rd  = rd;
    if (acc && !tmo && mr && !mw) e_mdr = rdv;
    if (mis) e_align = 1'b1;
    if (tmo) e_bus = 1'b1;
    chk_mw(tag);
  endtask

  initial begin
    logic [31:0] r, a;
    int lat;

    rst = 1'b1;
    XM_MemtoReg = 1'b0; XM_RegWrite = 1'b0; XM_MemRead = 1'b0;
    XM_MemWrite = 1'b0; XM_branch = 1'b1; ALUout = 32'd0; XM_MD = 32'd0;
    XM_RD = 5'd0; XM_BT = 32'h1234_5678; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",   32'(dmem_req), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.pcsrc", 32'(PCSrc), 32'd0);
    chk_mw("rst");
    rst = 1'b0;

    // Directed cases.
    do_op("alu",    1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_002A, 32'd0, 5'd5, 0, 32'd0);
    do_op("ld0",    1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'd0, 5'd6, 0, 32'hDEAD_BEEF);
    do_op("st3",    1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h55AA_55AA, 5'd0, 3, 32'd0);
    do_op("mis",    1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'd0, 5'd8, 0, 32'h1111_1111);
    do_op("tmo",    1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0108, 32'd0, 5'd9, NEVER, 32'd0);
    do_op("rw",     1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_010C, 32'hCAFE_F00D, 5'd3, 1, 32'h7777_7777);

    // Reset in the second WAIT cycle of an unanswered load.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; model_reset();
    do_op("ackTO",  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0110, 32'd0, 5'd4, TO, 32'hA5A5_0F0F);
    XM_MemRead = 1'b1; XM_MemWrite = 1'b0; XM_MemtoReg = 1'b1; XM_RegWrite = 1'b1;
    ALUout = 32'h0000_0200; XM_RD = 5'd7; XM_branch = 1'b0; dmem_ack = 1'b0;
    #1; chk("rw0.stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; XM_branch = 1'b1;
    #1;
    chk("rw2.req",   32'(dmem_req), 32'd0);
    chk("rw2.stall", 32'(stall), 32'd0);
    chk("rw2.pcsrc", 32'(PCSrc), 32'd0);
    @(posedge clk); #1;
    model_reset();
    chk_mw("rstw");
    rst = 1'b0; XM_branch = 1'b0;
    do_op("postrst", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'd0, 5'd10, 0, 32'h0BAD_C0DE);

    // Random ops.
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      a = $urandom;
      if (r[4:2] != 3'b000) a[1:0] = 2'b00;
      lat = int'(r[10:8]);
      if (lat > TO) lat = NEVER;
      do_op("rnd", r[0], r[1], r[5], r[6], a, $urandom, 5'(r[15:11]), lat, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
